// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
//   Shared definitions for the APB register slave, its master and its bench.
//   Contents:
//     apb_state_t   - completer FSM states
//     APB_ADDR_W    - default paddr width
//     APB_DATA_W    - default data / register width
//     APB_ID_VALUE  - read-only identification value returned at address 0
//     cnt_width()   - width of a down-counter that can hold 0..n
// ----------------------------------------------------------------------------
package apb_pkg;

   typedef enum logic [1:0] {
      APB_IDLE   = 2'd0,
      APB_SETUP  = 2'd1,
      APB_ACCESS = 2'd2
   } apb_state_t;

   localparam int                    APB_ADDR_W   = 4;
   localparam int                    APB_DATA_W   = 8;
   localparam logic [APB_DATA_W-1:0] APB_ID_VALUE = 8'hA5;

   // A counter loaded with n needs at least one bit even when n is 0.
   function automatic int cnt_width(input int n);
      return (n <= 0) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/apb_reg_slave_if.sv
// ----------------------------------------------------------------------------
// apb_reg_slave_if
//   APB bus bundle between one requester and one completer (single psel).
//   Signals:
//     paddr/pwrite/psel/penable/pwdata  requester -> completer
//     prdata/pready/pslverr             completer -> requester
//   Modports: master (drives the request), slave (drives the response).
// ----------------------------------------------------------------------------
interface apb_reg_slave_if #(
   parameter int ADDR_W = apb_pkg::APB_ADDR_W,
   parameter int DATA_W = apb_pkg::APB_DATA_W
) ();

   logic [ADDR_W-1:0] paddr;
   logic              pwrite;
   logic              psel;
   logic              penable;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output paddr, pwrite, psel, penable, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, pwrite, psel, penable, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apb_reg_bank.sv
// ----------------------------------------------------------------------------
// apb_reg_bank
//   Array of NUM_REGS DATA_W-bit registers with a one-cycle write strobe.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset (all registers -> 0)
//     we         write enable; caller guarantees addr selects a writable reg
//     addr       register index (also selects rdata)
//     wdata      write data
//     rdata      combinational read of the addressed register (0 if none)
//     regs_o     flat image, reg n at [n*DATA_W +: DATA_W]
//     wr_pulse   bit n high for the one cycle after reg n was written
// ----------------------------------------------------------------------------
module apb_reg_bank
   import apb_pkg::*;
#(
   parameter int ADDR_W   = APB_ADDR_W,
   parameter int DATA_W   = APB_DATA_W,
   parameter int NUM_REGS = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          addr,
   input  logic [DATA_W-1:0]          wdata,
   output logic [DATA_W-1:0]          rdata,
   output logic [NUM_REGS*DATA_W-1:0] regs_o,
   output logic [NUM_REGS-1:0]        wr_pulse
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [DATA_W-1:0] reg_q, reg_d;
         logic              pulse_q, pulse_d;
         logic              hit;

         assign hit = we && (addr == ADDR_W'(gi));

         always_comb begin
            reg_d   = hit ? wdata : reg_q;
            pulse_d = hit;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               reg_q   <= '0;
               pulse_q <= 1'b0;
            end else begin
               reg_q   <= reg_d;
               pulse_q <= pulse_d;
            end
         end

         assign regs_o[gi*DATA_W +: DATA_W] = reg_q;
         assign wr_pulse[gi]                = pulse_q;
      end
   endgenerate

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr == ADDR_W'(i)) rdata = regs_o[i*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/apb_reg_slave.sv
// ----------------------------------------------------------------------------
// apb_reg_slave
//   APB completer for a bank of NUM_REGS control registers. Address 0 is a
//   read-only ID, addresses 1..NUM_REGS-1 are read/write, everything above is
//   unmapped and answered with pslverr. WAIT_STATES extra ACCESS cycles are
//   inserted before pready.
//   Ports:
//     pclk, preset  clock, asynchronous active-high reset
//     apb           APB slave modport (paddr/pwrite/psel/penable/pwdata in,
//                   prdata/pready/pslverr out)
//     regs_o        flat register image, reg n at [n*DATA_W +: DATA_W]
//     wr_pulse      bit n high for one cycle after reg n is written
// ----------------------------------------------------------------------------
module apb_reg_slave
   import apb_pkg::*;
#(
   parameter int                ADDR_W      = APB_ADDR_W,
   parameter int                DATA_W      = APB_DATA_W,
   parameter int                NUM_REGS    = 12,
   parameter int                WAIT_STATES = 0,
   parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(APB_ID_VALUE)
) (
   input  logic                       pclk,
   input  logic                       preset,
   apb_reg_slave_if.slave             apb,
   output logic [NUM_REGS*DATA_W-1:0] regs_o,
   output logic [NUM_REGS-1:0]        wr_pulse
);

   localparam int                CNT_W      = cnt_width(WAIT_STATES);
   localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(WAIT_STATES);
   localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W+1)'(NUM_REGS);

   apb_state_t        state_q, state_d, phase;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              access_done;
   logic              is_id, in_range, err;
   logic              bank_we;
   logic [DATA_W-1:0] bank_rdata;

   // ---------------- state register ----------------
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q <= APB_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
      end
   end

   // Transfer completes in the current cycle.
   assign access_done = (state_q == APB_ACCESS) && apb.psel && apb.penable && (cnt_q == '0);

   // ---------------- next-state logic ----------------
   // The SETUP phase is the bus cycle in which psel&!penable is visible while
   // the FSM is idle. It is decoded from the bus rather than registered so that
   // the first penable cycle is already ACCESS; a zero-wait master that never
   // looks at pready therefore completes in its first ACCESS cycle. After a
   // completion the FSM drops to IDLE and a directly following SETUP is decoded
   // the same way, so back-to-back transfers need no idle cycle.
   always_comb begin
      phase = state_q;
      if (state_q == APB_IDLE && apb.psel && !apb.penable) phase = APB_SETUP;

      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;

      case (phase)
         APB_IDLE: begin
            // penable without a preceding setup is ignored
            state_d = APB_IDLE;
         end
         APB_SETUP: begin
            addr_d  = apb.paddr;
            write_d = apb.pwrite;
            wdata_d = apb.pwdata;
            cnt_d   = CNT_LOAD;
            state_d = APB_ACCESS;
         end
         APB_ACCESS: begin
            if (!apb.psel || access_done) begin
               // abort (psel dropped before pready) or normal completion
               state_d = APB_IDLE;
            end else begin
               state_d = APB_ACCESS;
               if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = APB_IDLE;
      endcase
   end

   // ---------------- decode ----------------
   assign is_id    = (addr_q == '0);
   assign in_range = ({1'b0, addr_q} < NUM_REGS_X);
   assign err      = write_q ? (is_id || !in_range) : !in_range;

   // ---------------- outputs ----------------
   // All responses are qualified by access_done, which is low whenever the
   // FSM is held in IDLE by reset.
   always_comb begin
      apb.pready  = access_done;
      apb.pslverr = access_done && err;
      bank_we     = access_done && write_q && !err;
      apb.prdata  = '0;
      if (access_done && !write_q) begin
         if (is_id)         apb.prdata = ID_VALUE;
         else if (in_range) apb.prdata = bank_rdata;
      end
   end

   apb_reg_bank #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_bank (
      .clk      (pclk),
      .rst      (preset),
      .we       (bank_we),
      .addr     (addr_q),
      .wdata    (wdata_q),
      .rdata    (bank_rdata),
      .regs_o   (regs_o),
      .wr_pulse (wr_pulse)
   );

endmodule
